store_buffer: RTL

- Sits directly downstream of the single-cycle core's data port (mem_write / data_addr / write_data).
- Queues word stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Stalls the core only when the FIFO is full.
- Optionally forwards buffered store data to loads.

---
 rtl/store_buffer_if.sv | 26 ++
 rtl/store_buffer.sv | 66 ++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: core store/load port and memory drain port of the store buffer.
// master = the store buffer itself, slave = the core/memory side around it.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          stall;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    modport master (
        input  st_valid, st_addr, st_data, ld_addr, mem_ready,
        output stall, ld_hit, ld_data, mem_valid, mem_addr, mem_wdata
    );
    modport slave (
        output st_valid, st_addr, st_data, ld_addr, mem_ready,
        input  stall, ld_hit, ld_data, mem_valid, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of word stores drained to memory over valid/ready.
// Define STORE_BUF_FWD_EN to forward the newest buffered store data to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    store_buffer_if.master           bus,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    assign bus.stall     = count == CW'(DEPTH);
    assign bus.mem_valid = count != '0;
    assign empty         = count == '0;
    assign push          = bus.st_valid && !bus.stall;
    assign pop           = bus.mem_valid && bus.mem_ready;
    assign bus.mem_addr  = bus.mem_valid ? addr_q[rd_ptr] : '0;
    assign bus.mem_wdata = bus.mem_valid ? data_q[rd_ptr] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // Entry storage needs no reset: only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.st_addr;
            data_q[wr_ptr] <= bus.st_data;
        end
    end
`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] fwd_idx;
    // Scan oldest to newest so the last match left standing is the newest store.
    always_comb begin
        bus.ld_hit  = 1'b0;
        bus.ld_data = '0;
        fwd_idx     = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (CW'(i) < count && addr_q[fwd_idx][AW-1:2] == bus.ld_addr[AW-1:2]) begin
                bus.ld_hit  = 1'b1;
                bus.ld_data = data_q[fwd_idx];
            end
        end
    end
`else
    assign bus.ld_hit  = 1'b0;
    assign bus.ld_data = '0;
`endif
endmodule
